// File: rtl/ps2_mouse_report_pkg.sv
// Shared constants, mode/state encodings and byte helpers for the PS/2 mouse
// report encoder and its sequence packer.
package ps2_mouse_report_pkg;

    localparam logic [7:0] MOUSE_PREFIX_TEXT  = 8'h1E;
    localparam logic [7:0] MOUSE_PREFIX_PIXEL = 8'h1F;

    localparam logic [2:0] SEQ_COUNT_TEXT  = 3'd4;
    localparam logic [2:0] SEQ_COUNT_PIXEL = 3'd6;

    typedef enum logic [1:0] {
        MOUSE_OFF     = 2'd0,
        MOUSE_BUTTONS = 2'd1,
        MOUSE_DRAG    = 2'd2,
        MOUSE_ALL     = 2'd3
    } mouse_mode_e;

    typedef enum logic [1:0] {
        OUT_EMPTY     = 2'd0,
        OUT_FULL      = 2'd1,
        OUT_FULL_PEND = 2'd2
    } out_state_e;

    function automatic logic [7:0] mouse_modifier(
        input logic meta,
        input logic alt,
        input logic ctrl,
        input logic shift,
        input logic middle,
        input logic right,
        input logic left
    );
        return {1'b1, meta, alt, ctrl, shift, middle, right, left};
    endfunction

    // Six-bit pixel coordinate field with the high marker bit set.
    function automatic logic [7:0] coord6_byte(input logic [5:0] v);
        return {2'b10, v};
    endfunction

endpackage

// File: rtl/ps2_mouse_report_pack.sv
// Combinational packer: modifier byte and coordinates of the selected format
// into a little-endian byte sequence plus its byte count.
module mouse_sequence_pack
    import ps2_mouse_report_pkg::*;
#(
    parameter int X_TEXT_BITS   = 7,
    parameter int Y_TEXT_BITS   = 6,
    parameter int X_SCREEN_BITS = 11,
    parameter int Y_SCREEN_BITS = 10
) (
    input  logic                     pixel_mode_i,
    input  logic [7:0]               modifier_i,
    input  logic [X_TEXT_BITS-1:0]   x_text_i,
    input  logic [Y_TEXT_BITS-1:0]   y_text_i,
    input  logic [X_SCREEN_BITS-1:0] x_screen_i,
    input  logic [Y_SCREEN_BITS-1:0] y_screen_i,
    output logic [47:0]              sequence_o,
    output logic [2:0]               count_o
);

    logic [6:0]  xt_ext;
    logic [6:0]  yt_ext;
    logic [11:0] xs_ext;
    logic [11:0] ys_ext;

    always_comb begin
        xt_ext = 7'(x_text_i);
        yt_ext = 7'(y_text_i);
        xs_ext = 12'(x_screen_i);
        ys_ext = 12'(y_screen_i);
        if (pixel_mode_i) begin
            sequence_o = {coord6_byte(ys_ext[5:0]), coord6_byte(ys_ext[11:6]),
                          coord6_byte(xs_ext[5:0]), coord6_byte(xs_ext[11:6]),
                          modifier_i, MOUSE_PREFIX_PIXEL};
            count_o    = SEQ_COUNT_PIXEL;
        end else begin
            sequence_o = {16'h0000, 1'b1, yt_ext, 1'b1, xt_ext,
                          modifier_i, MOUSE_PREFIX_TEXT};
            count_o    = SEQ_COUNT_TEXT;
        end
    end

endmodule

// File: rtl/ps2_mouse_report.sv
// Mouse state to terminal mouse-report encoder: change detection per report
// mode, one output slot held until ack, and a one-deep coalescing pending slot.
module ps2_mouse_report
    import ps2_mouse_report_pkg::*;
#(
    parameter int X_TEXT_BITS   = 7,
    parameter int Y_TEXT_BITS   = 6,
    parameter int X_SCREEN_BITS = 11,
    parameter int Y_SCREEN_BITS = 10
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [1:0]               mouse_control,
    input  logic                     mouse_pixel,
    input  logic                     keyboard_shift,
    input  logic                     keyboard_alt,
    input  logic                     keyboard_ctrl,
    input  logic                     keyboard_meta,
    input  logic                     mouse_state_ready,
    input  logic                     button_left,
    input  logic                     button_middle,
    input  logic                     button_right,
    input  logic [X_TEXT_BITS-1:0]   x_text,
    input  logic [Y_TEXT_BITS-1:0]   y_text,
    input  logic [X_SCREEN_BITS-1:0] x_screen,
    input  logic [Y_SCREEN_BITS-1:0] y_screen,
    input  logic                     sequence_ack,
    output logic [47:0]              sequence_out,
    output logic [2:0]               sequence_out_count,
    output logic                     event_dropped
);

    out_state_e                 state_q, state_d;
    logic [47:0]                seq_q, seq_d;
    logic [2:0]                 count_q, count_d;
    logic [47:0]                pend_seq_q, pend_seq_d;
    logic [2:0]                 pend_count_q, pend_count_d;
    logic                       pend_btn_q, pend_btn_d;
    logic                       dropped_q, dropped_d;
    logic [2:0]                 last_btn_q, last_btn_d;
    logic [X_TEXT_BITS-1:0]     last_xt_q, last_xt_d;
    logic [Y_TEXT_BITS-1:0]     last_yt_q, last_yt_d;
    logic [X_SCREEN_BITS-1:0]   last_xs_q, last_xs_d;
    logic [Y_SCREEN_BITS-1:0]   last_ys_q, last_ys_d;

    mouse_mode_e mode;
    logic [2:0]  buttons;
    logic [7:0]  modifier;
    logic [47:0] packed_seq;
    logic [2:0]  packed_count;
    logic        btn_changed;
    logic        coord_changed;
    logic        button_event;
    logic        motion_event;
    logic        new_event;
    logic        pend_flush;
    logic        accept;

    assign mode     = mouse_mode_e'(mouse_control);
    assign buttons  = {button_middle, button_right, button_left};
    assign modifier = mouse_modifier(keyboard_meta, keyboard_alt, keyboard_ctrl,
                                     keyboard_shift, button_middle, button_right,
                                     button_left);

    mouse_sequence_pack #(
        .X_TEXT_BITS  (X_TEXT_BITS),
        .Y_TEXT_BITS  (Y_TEXT_BITS),
        .X_SCREEN_BITS(X_SCREEN_BITS),
        .Y_SCREEN_BITS(Y_SCREEN_BITS)
    ) u_pack (
        .pixel_mode_i(mouse_pixel),
        .modifier_i  (modifier),
        .x_text_i    (x_text),
        .y_text_i    (y_text),
        .x_screen_i  (x_screen),
        .y_screen_i  (y_screen),
        .sequence_o  (packed_seq),
        .count_o     (packed_count)
    );

    // Motion is judged only on the coordinate set of the currently selected format.
    assign btn_changed   = (buttons != last_btn_q);
    assign coord_changed = mouse_pixel ? ((x_screen != last_xs_q) || (y_screen != last_ys_q))
                                       : ((x_text != last_xt_q) || (y_text != last_yt_q));
    assign button_event  = mouse_state_ready && btn_changed && (mode != MOUSE_OFF);
    assign motion_event  = mouse_state_ready && coord_changed && !btn_changed &&
                           ((mode == MOUSE_ALL) || ((mode == MOUSE_DRAG) && (|buttons)));
    assign new_event     = button_event || motion_event;
    assign pend_flush    = mouse_state_ready && (mode == MOUSE_OFF);

    always_comb begin
        state_d      = state_q;
        seq_d        = seq_q;
        count_d      = count_q;
        pend_seq_d   = pend_seq_q;
        pend_count_d = pend_count_q;
        pend_btn_d   = pend_btn_q;
        dropped_d    = 1'b0;
        last_btn_d   = last_btn_q;
        last_xt_d    = last_xt_q;
        last_yt_d    = last_yt_q;
        last_xs_d    = last_xs_q;
        last_ys_d    = last_ys_q;
        accept       = 1'b0;

        case (state_q)
            OUT_EMPTY: begin
                if (new_event) begin
                    seq_d   = packed_seq;
                    count_d = packed_count;
                    accept  = 1'b1;
                    state_d = OUT_FULL;
                end
            end
            OUT_FULL: begin
                if (sequence_ack) begin
                    if (new_event) begin
                        seq_d   = packed_seq;
                        count_d = packed_count;
                        accept  = 1'b1;
                    end else begin
                        seq_d   = '0;
                        count_d = '0;
                        state_d = OUT_EMPTY;
                    end
                end else if (new_event) begin
                    pend_seq_d   = packed_seq;
                    pend_count_d = packed_count;
                    pend_btn_d   = button_event;
                    accept       = 1'b1;
                    state_d      = OUT_FULL_PEND;
                end
            end
            OUT_FULL_PEND: begin
                if (pend_flush) begin
                    // Turning reporting off discards whatever is still waiting.
                    pend_seq_d   = '0;
                    pend_count_d = '0;
                    pend_btn_d   = 1'b0;
                    if (sequence_ack) begin
                        seq_d   = '0;
                        count_d = '0;
                        state_d = OUT_EMPTY;
                    end else begin
                        state_d = OUT_FULL;
                    end
                end else if (sequence_ack) begin
                    seq_d   = pend_seq_q;
                    count_d = pend_count_q;
                    if (new_event) begin
                        pend_seq_d   = packed_seq;
                        pend_count_d = packed_count;
                        pend_btn_d   = button_event;
                        accept       = 1'b1;
                    end else begin
                        pend_seq_d   = '0;
                        pend_count_d = '0;
                        pend_btn_d   = 1'b0;
                        state_d      = OUT_FULL;
                    end
                end else if (new_event) begin
                    if (pend_btn_q) begin
                        dropped_d = 1'b1;
                    end else begin
                        pend_seq_d   = packed_seq;
                        pend_count_d = packed_count;
                        pend_btn_d   = button_event;
                        accept       = 1'b1;
                    end
                end
            end
            default: begin
                state_d = OUT_EMPTY;
            end
        endcase

        if (accept || pend_flush) begin
            last_btn_d = buttons;
            last_xt_d  = x_text;
            last_yt_d  = y_text;
            last_xs_d  = x_screen;
            last_ys_d  = y_screen;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= OUT_EMPTY;
            seq_q        <= '0;
            count_q      <= '0;
            pend_seq_q   <= '0;
            pend_count_q <= '0;
            pend_btn_q   <= 1'b0;
            dropped_q    <= 1'b0;
            last_btn_q   <= '0;
            last_xt_q    <= '0;
            last_yt_q    <= '0;
            last_xs_q    <= '0;
            last_ys_q    <= '0;
        end else begin
            state_q      <= state_d;
            seq_q        <= seq_d;
            count_q      <= count_d;
            pend_seq_q   <= pend_seq_d;
            pend_count_q <= pend_count_d;
            pend_btn_q   <= pend_btn_d;
            dropped_q    <= dropped_d;
            last_btn_q   <= last_btn_d;
            last_xt_q    <= last_xt_d;
            last_yt_q    <= last_yt_d;
            last_xs_q    <= last_xs_d;
            last_ys_q    <= last_ys_d;
        end
    end

    assign sequence_out       = seq_q;
    assign sequence_out_count = count_q;
    assign event_dropped      = dropped_q;

endmodule
